// File: rtl/pc_sequencer.sv
// Program-counter register and fetch sequencer: IDLE/RUN/DONE program handshake,
// relative/absolute branch application and a saturating RUN-cycle counter.
module pc_sequencer #(
  parameter int D        = 12,
  parameter int CW       = 16,
  parameter int START_PC = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          stall,
  input  logic          halt,
  input  logic          branch_en,
  input  logic          branch_abs,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] cyc_cnt
);

  localparam logic [D-1:0] START = D'(START_PC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      prog_ctr <= START;
      cyc_cnt  <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (Start) begin
            state    <= RUN;
            prog_ctr <= START;
            cyc_cnt  <= '0;
            running  <= 1'b1;
            done     <= 1'b0;
          end
        end

        RUN: begin
          if (Start) begin
            prog_ctr <= START;
            cyc_cnt  <= '0;
          end else begin
            // The halting cycle is itself a RUN cycle, so it is counted too.
            if (cyc_cnt != '1)
              cyc_cnt <= cyc_cnt + 1'b1;

            if (halt && !stall) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else if (stall) begin
              prog_ctr <= prog_ctr;
            end else if (branch_en && branch_abs) begin
              prog_ctr <= target;
            end else if (branch_en) begin
              // D-bit add: two's-complement offset, wraps modulo 2**D.
              prog_ctr <= prog_ctr + target;
            end else begin
              prog_ctr <= prog_ctr + 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; a second instance with CW=4 and
// START_PC=100 shares the stimulus to cover counter saturation and launch address.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Start, stall, halt, branch_en, branch_abs;
  logic [11:0] target;
  logic [11:0] prog_ctr, prog_ctr4;
  logic        running, done, running4, done4;
  logic [15:0] cyc_cnt;
  logic [3:0]  cyc_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pc_sequencer #(.D(12), .CW(16), .START_PC(0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_abs(branch_abs), .target(target),
    .prog_ctr(prog_ctr), .running(running), .done(done), .cyc_cnt(cyc_cnt)
  );

  pc_sequencer #(.D(12), .CW(4), .START_PC(100)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_abs(branch_abs), .target(target),
    .prog_ctr(prog_ctr4), .running(running4), .done(done4), .cyc_cnt(cyc_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [11:0] pc, input logic run,
                           input logic dn, input logic [15:0] cc);
    chk({tag, ".pc"},  32'(prog_ctr), 32'(pc));
    chk({tag, ".run"}, 32'(running),  32'(run));
    chk({tag, ".done"}, 32'(done),    32'(dn));
    chk({tag, ".cyc"}, 32'(cyc_cnt),  32'(cc));
  endtask

  task automatic br(input logic abs, input logic [11:0] t);
    branch_en = 1'b1; branch_abs = abs; target = t;
  endtask

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; stall = 1'b0; halt = 1'b0;
    branch_en = 1'b0; branch_abs = 1'b0; target = '0;
    #1;
    step(); step();
    chk_state("reset", 12'd0, 1'b0, 1'b0, 16'd0);
    chk("reset.pc4", 32'(prog_ctr4), 32'd100);

    // Launch and straight-line fetch
    Reset = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    chk_state("launch", 12'd0, 1'b1, 1'b0, 16'd0);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("seq.pc",  32'(prog_ctr), 32'(i));
      chk("seq.cyc", 32'(cyc_cnt),  32'(i));
    end

    // Relative back, relative forward, absolute
    br(1'b0, 12'hFFB); step(); chk_state("rel_neg", 12'd5,   1'b1, 1'b0, 16'd11);
    br(1'b0, 12'd20);  step(); chk_state("rel_pos", 12'd25,  1'b1, 1'b0, 16'd12);
    br(1'b1, 12'h3A0); step(); chk_state("abs",     12'h3A0, 1'b1, 1'b0, 16'd13);

    // Stall overrides a pending branch; cycles still counted
    br(1'b1, 12'd7);   step(); chk("to7", 32'(prog_ctr), 32'd7);
    stall = 1'b1; br(1'b1, 12'd100);
    step(); chk_state("stall1", 12'd7, 1'b1, 1'b0, 16'd15);
    step(); chk_state("stall2", 12'd7, 1'b1, 1'b0, 16'd16);
    step(); chk_state("stall3", 12'd7, 1'b1, 1'b0, 16'd17);
    stall = 1'b0; branch_en = 1'b0;
    step(); chk_state("unstall", 12'd8, 1'b1, 1'b0, 16'd18);

    // Wrap-around on +1 and on relative +1; spin and back-one
    br(1'b1, 12'hFFF); step(); chk("top", 32'(prog_ctr), 32'hFFF);
    branch_en = 1'b0;  step(); chk("wrap_inc", 32'(prog_ctr), 32'h0);
    br(1'b1, 12'hFFF); step();
    br(1'b0, 12'd1);   step(); chk("wrap_rel", 32'(prog_ctr), 32'h0);
    br(1'b0, 12'd0);   step(); chk("spin", 32'(prog_ctr), 32'h0);
    br(1'b0, 12'hFFF); step(); chk_state("back1", 12'hFFF, 1'b1, 1'b0, 16'd24);

    // Halt blocked by stall, then taken; DONE ignores datapath inputs
    br(1'b1, 12'd40);  step(); chk("to40", 32'(prog_ctr), 32'd40);
    branch_en = 1'b0; halt = 1'b1; stall = 1'b1;
    step(); chk_state("halt_stall", 12'd40, 1'b1, 1'b0, 16'd26);
    stall = 1'b0;
    step(); chk_state("halt", 12'd40, 1'b0, 1'b1, 16'd27);
    br(1'b1, 12'd99);
    step(); step(); chk_state("done_hold", 12'd40, 1'b0, 1'b1, 16'd27);

    // Relaunch from DONE, then Reset aborts mid-RUN
    halt = 1'b0; branch_en = 1'b0; Start = 1'b1;
    step(); Start = 1'b0;
    chk_state("relaunch", 12'd0, 1'b1, 1'b0, 16'd0);
    br(1'b1, 12'd33); step(); chk("to33", 32'(prog_ctr), 32'd33);
    branch_en = 1'b0; Reset = 1'b1;
    step(); Reset = 1'b0;
    chk_state("abort", 12'd0, 1'b0, 1'b0, 16'd0);

    // Restart while running
    Start = 1'b1; step(); Start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_restart", 32'(prog_ctr), 32'd5);
    Start = 1'b1; step(); Start = 1'b0;
    chk_state("restart", 12'd0, 1'b1, 1'b0, 16'd0);

    // Reset beats Start; IDLE ignores branches
    Reset = 1'b1; Start = 1'b1; step();
    Reset = 1'b0; Start = 1'b0;
    chk_state("rst_wins", 12'd0, 1'b0, 1'b0, 16'd0);
    br(1'b1, 12'd55); step();
    chk_state("idle_hold", 12'd0, 1'b0, 1'b0, 16'd0);
    branch_en = 1'b0;

    // Saturation of the 4-bit counter and non-zero launch address
    Start = 1'b1; step(); Start = 1'b0;
    chk("sat.pc4_launch", 32'(prog_ctr4), 32'd100);
    chk("sat.run4", 32'(running4), 32'd1);
    for (int i = 0; i < 14; i++) step();
    chk("sat.cyc4_14", 32'(cyc_cnt4), 32'd14);
    for (int i = 0; i < 6; i++) step();
    chk("sat.cyc4_20", 32'(cyc_cnt4), 32'd15);
    chk("sat.cyc16_20", 32'(cyc_cnt), 32'd20);
    chk("sat.pc4", 32'(prog_ctr4), 32'd120);
    chk("sat.done4", 32'(done4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
